if_stage: RTL and testbench

Instruction-fetch stage of the five-stage LoongArch-32 pipeline, sitting between the instruction SRAM-like port and the decode stage. It generates the sequential PC and issues at most one fetch request at a time. It discards wrong-path fetches when decode redirects via `br_bus`. It buffers a returned instruction while decode stalls and presents `{inst, pc}` to decode through the valid/allowin handshake.

---
 rtl/if_stage.sv | 118 +++++++++++
 tb/tb_if_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: sequential PC generation, single outstanding fetch
// on an SRAM-like port, wrong-path discard on branch redirect, and a one-entry
// instruction buffer that holds the fetched word while decode stalls.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ds_allowin,
    input  logic [32:0] br_bus,
    output logic        fs_to_ds_valid,
    output logic [63:0] fs_to_ds_bus,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata
);

    localparam logic [31:0] PC_INIT = RESET_PC - 32'd4;

    logic [31:0] fs_pc;
    logic        fs_valid;
    logic        outstanding;
    logic        drop;
    logic [31:0] inst_buf;
    logic        buf_valid;
    logic        br_pending;
    logic [31:0] br_target_r;

    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] nextpc;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        addr_hs;
    logic        fs_to_ds_fire;

    // Next-PC selection, handshake terms and decode-side outputs
    always_comb begin
        br_taken       = br_bus[32];
        br_target      = br_bus[31:0];
        nextpc         = br_pending ? br_target_r : fs_pc + 32'd4;
        fs_ready_go    = buf_valid | (outstanding & inst_sram_data_ok & ~drop);
        fs_allowin     = ~fs_valid | (fs_ready_go & ds_allowin);
        // Held low during reset so the SRAM never sees a request from reset state
        inst_sram_req  = ~reset & ~br_taken & fs_allowin
                         & (~outstanding | inst_sram_data_ok);
        addr_hs        = inst_sram_req & inst_sram_addr_ok;
        fs_to_ds_valid = fs_valid & fs_ready_go & ~br_taken;
        fs_to_ds_fire  = fs_to_ds_valid & ds_allowin;
        fs_to_ds_bus   = {(buf_valid ? inst_buf : inst_sram_rdata), fs_pc};
    end

    // Fixed read-only word access on the SRAM port
    always_comb begin
        inst_sram_wr    = 1'b0;
        inst_sram_size  = 2'b10;
        inst_sram_wstrb = '0;
        inst_sram_addr  = nextpc;
        inst_sram_wdata = '0;
    end

    // Fetch state; later statements take priority, so a branch overrides everything
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_pc       <= PC_INIT;
            fs_valid    <= 1'b0;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            inst_buf    <= '0;
            buf_valid   <= 1'b0;
            br_pending  <= 1'b0;
            br_target_r <= '0;
        end else begin
            if (addr_hs) begin
                fs_pc       <= nextpc;
                fs_valid    <= 1'b1;
                outstanding <= 1'b1;
                br_pending  <= 1'b0;
            end else if (inst_sram_data_ok) begin
                outstanding <= 1'b0;
            end

            if (inst_sram_data_ok && drop) begin
                drop <= 1'b0;
            end

            if (inst_sram_data_ok && !drop && fs_valid && !ds_allowin && !br_taken) begin
                inst_buf  <= inst_sram_rdata;
                buf_valid <= 1'b1;
            end

            if (fs_to_ds_fire) begin
                buf_valid <= 1'b0;
                if (!addr_hs) begin
                    fs_valid <= 1'b0;
                end
            end

            if (br_taken) begin
                br_pending  <= 1'b1;
                br_target_r <= br_target;
                fs_valid    <= 1'b0;
                buf_valid   <= 1'b0;
                // Only a fetch whose data is still to come needs discarding later
                if (outstanding && !inst_sram_data_ok) begin
                    drop <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: scripted cycle table, reset/wrap sequences, then
// randomized traffic checked against a program-order fetch/decode model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h1c00_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_allowin;
    logic [32:0] br_bus;
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk               (clk),
        .reset             (reset),
        .ds_allowin        (ds_allowin),
        .br_bus            (br_bus),
        .fs_to_ds_valid    (fs_to_ds_valid),
        .fs_to_ds_bus      (fs_to_ds_bus),
        .inst_sram_req     (req),
        .inst_sram_wr      (wr),
        .inst_sram_size    (size),
        .inst_sram_wstrb   (wstrb),
        .inst_sram_addr    (addr),
        .inst_sram_wdata   (wdata),
        .inst_sram_addr_ok (aok),
        .inst_sram_data_ok (dok),
        .inst_sram_rdata   (rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ds;
        logic        aok;
        logic        dok;
        logic [31:0] rdata;
        logic        brt;
        logic [31:0] btgt;
        logic        ereq;
        logic [31:0] eaddr;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] einst;
    } vec_t;

    localparam int NV = 20;
    vec_t tv[NV];

    function automatic vec_t mk(input logic ds_i, input logic aok_i, input logic dok_i,
                                input logic [31:0] rd_i, input logic brt_i,
                                input logic [31:0] tgt_i, input logic ereq_i,
                                input logic [31:0] eaddr_i, input logic ev_i,
                                input logic [31:0] epc_i, input logic [31:0] einst_i);
        vec_t v;
        v.ds = ds_i; v.aok = aok_i; v.dok = dok_i; v.rdata = rd_i;
        v.brt = brt_i; v.btgt = tgt_i; v.ereq = ereq_i; v.eaddr = eaddr_i;
        v.ev = ev_i; v.epc = epc_i; v.einst = einst_i;
        return v;
    endfunction

    // Instruction memory contents as seen by the random phase
    function automatic logic [31:0] memf(input logic [31:0] a);
        return {a[7:0], a[31:8]} ^ 32'hC3A5_0F1E;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input logic ds_i, input logic aok_i, input logic dok_i,
                         input logic [31:0] rd_i, input logic brt_i, input logic [31:0] tgt_i);
        ds_allowin = ds_i;
        aok        = aok_i;
        dok        = dok_i;
        rdata      = rd_i;
        br_bus     = {brt_i, tgt_i};
    endtask

    localparam logic [31:0] I0   = 32'h0280_0400;
    localparam logic [31:0] I1   = 32'h0280_0421;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;
    localparam logic [31:0] I100 = 32'h1500_0001;
    localparam logic [31:0] I104 = 32'h1500_0002;
    localparam logic [31:0] I200 = 32'h2900_0003;
    localparam logic [31:0] I204 = 32'h2900_0004;
    localparam logic [31:0] WW   = 32'h0123_4567;

    logic [31:0] pend[$];
    logic [31:0] exp_fetch;
    logic [31:0] exp_dpc;
    logic [31:0] tgt;
    logic        brt;
    logic        pv;
    logic        pds;
    logic [63:0] pbus;
    int          idle;
    int          xfers;

    initial begin
        // Scripted cycles starting from reset release
        tv[0]  = mk(1, 1, 0, 0,    0, 0,            1, 32'h1c00_0000, 0, 0, 0);
        tv[1]  = mk(1, 1, 1, I0,   0, 0,            1, 32'h1c00_0004, 1, 32'h1c00_0000, I0);
        tv[2]  = mk(0, 1, 1, I1,   0, 0,            0, 0,             1, 32'h1c00_0004, I1);
        tv[3]  = mk(0, 1, 0, 0,    0, 0,            0, 0,             1, 32'h1c00_0004, I1);
        tv[4]  = mk(0, 1, 0, 0,    0, 0,            0, 0,             1, 32'h1c00_0004, I1);
        tv[5]  = mk(1, 1, 0, 0,    0, 0,            1, 32'h1c00_0008, 1, 32'h1c00_0004, I1);
        tv[6]  = mk(1, 1, 0, 0,    1, 32'h1c00_0100, 0, 0,            0, 0, 0);
        tv[7]  = mk(1, 1, 0, 0,    0, 0,            0, 0,             0, 0, 0);
        tv[8]  = mk(1, 1, 1, DEAD, 0, 0,            1, 32'h1c00_0100, 0, 0, 0);
        tv[9]  = mk(1, 1, 1, I100, 0, 0,            1, 32'h1c00_0104, 1, 32'h1c00_0100, I100);
        tv[10] = mk(1, 1, 1, I104, 1, 32'h1c00_0200, 0, 0,            0, 0, 0);
        tv[11] = mk(1, 0, 0, 0,    0, 0,            1, 32'h1c00_0200, 0, 0, 0);
        tv[12] = mk(1, 0, 0, 0,    0, 0,            1, 32'h1c00_0200, 0, 0, 0);
        tv[13] = mk(1, 0, 0, 0,    0, 0,            1, 32'h1c00_0200, 0, 0, 0);
        tv[14] = mk(1, 0, 0, 0,    0, 0,            1, 32'h1c00_0200, 0, 0, 0);
        tv[15] = mk(1, 1, 0, 0,    0, 0,            1, 32'h1c00_0200, 0, 0, 0);
        tv[16] = mk(1, 1, 1, I200, 0, 0,            1, 32'h1c00_0204, 1, 32'h1c00_0200, I200);
        tv[17] = mk(1, 0, 1, I204, 0, 0,            1, 32'h1c00_0208, 1, 32'h1c00_0204, I204);
        tv[18] = mk(1, 0, 0, 0,    0, 0,            1, 32'h1c00_0208, 0, 0, 0);
        tv[19] = mk(1, 1, 0, 0,    0, 0,            1, 32'h1c00_0208, 0, 0, 0);

        reset = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", fs_to_ds_valid, 0);
        chk("reset_req", req, 0);
        chk("const_wr", wr, 0);
        chk("const_size", size, 2'b10);
        chk("const_wstrb", wstrb, 0);
        chk("const_wdata", wdata, 0);
        #1 reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(posedge clk);
            #1;
            drive(tv[i].ds, tv[i].aok, tv[i].dok, tv[i].rdata, tv[i].brt, tv[i].btgt);
            #1;
            chk($sformatf("v%0d_req", i), req, tv[i].ereq);
            if (tv[i].ereq) chk($sformatf("v%0d_addr", i), addr, tv[i].eaddr);
            chk($sformatf("v%0d_valid", i), fs_to_ds_valid, tv[i].ev);
            if (tv[i].ev) chk($sformatf("v%0d_bus", i), fs_to_ds_bus, {tv[i].einst, tv[i].epc});
        end

        // Async reset while data is returning for 1c000208
        @(posedge clk);
        #1;
        drive(0, 0, 1, 32'h1111_2222, 0, 0);
        #1;
        chk("pre_reset_valid", fs_to_ds_valid, 1);
        chk("pre_reset_bus", fs_to_ds_bus, {32'h1111_2222, 32'h1c00_0208});
        #1 reset = 1'b1;
        #1;
        chk("async_reset_valid", fs_to_ds_valid, 0);
        chk("async_reset_req", req, 0);
        drive(1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        drive(1, 1, 0, 0, 0, 0);
        #1;
        chk("post_reset_req", req, 1);
        chk("post_reset_addr", addr, RESET_PC);

        // Branch to the top of the address space: the fetch after it wraps to 0
        @(posedge clk);
        #1;
        drive(1, 1, 0, 0, 1, 32'hFFFF_FFFC);
        #1;
        chk("wrap_br_req", req, 0);
        @(posedge clk);
        #1;
        drive(1, 1, 1, DEAD, 0, 0);
        #1;
        chk("wrap_drop_valid", fs_to_ds_valid, 0);
        chk("wrap_tgt_req", req, 1);
        chk("wrap_tgt_addr", addr, 32'hFFFF_FFFC);
        @(posedge clk);
        #1;
        drive(1, 1, 1, WW, 0, 0);
        #1;
        chk("wrap_bus", fs_to_ds_bus, {WW, 32'hFFFF_FFFC});
        chk("wrap_valid", fs_to_ds_valid, 1);
        chk("wrap_next_addr", addr, 32'h0000_0000);

        // Random phase from a fresh reset
        @(posedge clk);
        #1;
        drive(1, 0, 0, 0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        pend.delete();
        exp_fetch = RESET_PC;
        exp_dpc   = RESET_PC;
        pv = 1'b0; pds = 1'b0; pbus = '0;
        idle = 0; xfers = 0;

        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            brt = (($urandom % 20) == 0);
            tgt = RESET_PC + ($urandom_range(0, 63) << 2);
            ds_allowin = (($urandom % 4) != 0);
            aok        = (($urandom % 3) != 0);
            dok        = (pend.size() > 0) && (($urandom % 2) == 0);
            rdata      = dok ? memf(pend[0]) : $urandom;
            br_bus     = {brt, tgt};
            #1;
            if (brt) begin
                chk("rnd_br_no_req", req, 0);
                chk("rnd_br_no_valid", fs_to_ds_valid, 0);
            end
            if (pv && !pds && !brt) begin
                chk("rnd_hold_valid", fs_to_ds_valid, 1);
                chk("rnd_hold_bus", fs_to_ds_bus, pbus);
            end
            if (req && aok) begin
                chk("rnd_fetch_addr", addr, exp_fetch);
                chk("rnd_one_outstanding", (pend.size() == 0) || dok, 1);
            end
            if (fs_to_ds_valid && ds_allowin) begin
                chk("rnd_dec_pc", fs_to_ds_bus[31:0], exp_dpc);
                chk("rnd_dec_inst", fs_to_ds_bus[63:32], memf(exp_dpc));
                exp_dpc = exp_dpc + 32'd4;
                xfers++;
                idle = 0;
            end else begin
                idle++;
            end
            if (idle > 100) begin
                chk("rnd_liveness_idle", idle, 0);
                idle = 0;
            end
            if (dok) void'(pend.pop_front());
            if (req && aok) begin
                pend.push_back(addr);
                exp_fetch = exp_fetch + 32'd4;
            end
            if (brt) begin
                exp_fetch = tgt;
                exp_dpc   = tgt;
            end
            pv   = fs_to_ds_valid;
            pds  = ds_allowin;
            pbus = fs_to_ds_bus;
        end
        chk("rnd_min_transfers", xfers >= 300, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
